io_seg_display: RTL

IO_SEG_DISPLAY -- requirements
Module: io_seg_display

---
 rtl/io_seg_display_if.sv | 25 ++
 rtl/io_seg_display.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/io_seg_display_if.sv
// Port bundle for the 8-digit seven-segment display block:
// CPU output-port values in, multiplexed segment/anode/dp drive out.
interface io_seg_display_if;
    logic [31:0] out_port0;
    logic [31:0] out_port1;
    logic [6:0]  seg_n;
    logic [7:0]  an_n;
    logic        dp_n;

    modport master (
        output out_port0,
        output out_port1,
        input  seg_n,
        input  an_n,
        input  dp_n
    );

    modport slave (
        input  out_port0,
        input  out_port1,
        output seg_n,
        output an_n,
        output dp_n
    );
endinterface

// File: rtl/io_seg_display.sv
// Two 16-bit CPU ports shown as two 4-digit decimal groups on a
// multiplexed 8-digit display; one shared serial double-dabble converter.
module io_seg_display #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input logic             clock,
    input logic             reset,
    io_seg_display_if.slave bus
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        LOAD,
        SHIFT,
        STORE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [3:0]    cnt;
    logic [13:0]   opnd;
    logic [15:0]   acc;
    logic [15:0]   adj;
    logic          ovf_cur;
    logic          sel;
    logic [15:0]   port_v;
    logic [15:0]   bcd0;
    logic [15:0]   bcd1;
    logic          ovf0;
    logic          ovf1;
    logic [PW-1:0] pres;
    logic [2:0]    idx;
    logic [15:0]   grp;
    logic          grp_ovf;
    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    seg_q;
    logic [7:0]    an_q;
    logic          dp_q;
    logic          unused_hi;

    // Only the low halfword of each port is displayed.
    assign unused_hi = ^{bus.out_port0[31:16], bus.out_port1[31:16]};

    assign bus.seg_n = seg_q;
    assign bus.an_n  = an_q;
    assign bus.dp_n  = dp_q;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        port_v = sel ? bus.out_port1[15:0] : bus.out_port0[15:0];
    end

    always_comb begin
        adj = acc;
        for (int n = 0; n < 4; n++) begin
            if (acc[4*n +: 4] >= 4'd5) begin
                adj[4*n +: 4] = acc[4*n +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:    state_nx = SHIFT;
            SHIFT:   if (cnt == 4'd13) state_nx = STORE;
            STORE:   state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= '0;
            opnd    <= '0;
            acc     <= '0;
            ovf_cur <= 1'b0;
            sel     <= 1'b0;
            bcd0    <= '0;
            bcd1    <= '0;
            ovf0    <= 1'b0;
            ovf1    <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    cnt     <= '0;
                    acc     <= '0;
                    ovf_cur <= (port_v > 16'd9999);
                    opnd    <= (port_v > 16'd9999) ? 14'd9999 : port_v[13:0];
                end
                SHIFT: begin
                    {acc, opnd} <= {adj[14:0], opnd, 1'b0};
                    cnt         <= cnt + 4'd1;
                end
                STORE: begin
                    if (sel) begin
                        bcd1 <= acc;
                        ovf1 <= ovf_cur;
                    end else begin
                        bcd0 <= acc;
                        ovf0 <= ovf_cur;
                    end
                    sel <= ~sel;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pres <= '0;
            idx  <= '0;
        end else if (pres == PW'(SCAN_DIV - 1)) begin
            pres <= '0;
            idx  <= idx + 3'd1;
        end else begin
            pres <= pres + 1'b1;
        end
    end

    always_comb begin
        grp     = idx[2] ? bcd1 : bcd0;
        grp_ovf = idx[2] ? ovf1 : ovf0;
        digit   = grp[{idx[1:0], 2'b00} +: 4];
        blank   = 1'b0;
        case (idx[1:0])
            2'd1:    blank = (grp[15:4] == 12'd0);
            2'd2:    blank = (grp[15:8] == 8'd0);
            2'd3:    blank = (grp[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
        blank = blank & BLANK_LZ;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            an_q  <= 8'b1111_1110;
            seg_q <= 7'b1000000;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= ~(8'b1 << idx);
            seg_q <= blank ? 7'b1111111 : seg_of(digit);
            dp_q  <= ~((idx[1:0] == 2'd3) & grp_ovf);
        end
    end
endmodule
